// File: rtl/ahfp_add_arb.sv
// Two-requester front end for a single shared IEEE-754 single-precision adder.
// Each accepted operand pair walks IDLE -> LOAD -> EXEC -> RESP and is returned
// with the index of the requester that supplied it.

// Combinational single-precision adder, round-to-nearest-even.
module ahfp_add (
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  logic        w_swap;
  logic [31:0] w_big;
  logic [31:0] w_sml;
  logic [7:0]  w_eb;
  logic [7:0]  w_es;
  logic [7:0]  w_eb_n;
  logic [7:0]  w_es_n;
  logic [7:0]  w_diff;
  logic [26:0] w_mb;
  logic [26:0] w_ms;
  logic        w_sub;
  logic [26:0] w_ms_sh;
  logic        w_sticky;
  logic [27:0] w_sum;
  logic [26:0] w_m;
  logic [9:0]  w_e;
  logic        w_rnd;
  logic [24:0] w_sig25;
  logic [23:0] w_sig;

  // Order operands by magnitude so alignment always shifts the smaller one.
  assign w_swap = (datab[30:0] > dataa[30:0]);
  assign w_big  = w_swap ? datab : dataa;
  assign w_sml  = w_swap ? dataa : datab;
  assign w_eb   = w_big[30:23];
  assign w_es   = w_sml[30:23];
  // Denormals use exponent 1 with no hidden bit.
  assign w_eb_n = (w_eb == 8'd0) ? 8'd1 : w_eb;
  assign w_es_n = (w_es == 8'd0) ? 8'd1 : w_es;
  assign w_diff = w_eb_n - w_es_n;
  assign w_mb   = {(w_eb != 8'd0), w_big[22:0], 3'b000};
  assign w_ms   = {(w_es != 8'd0), w_sml[22:0], 3'b000};
  assign w_sub  = w_big[31] ^ w_sml[31];

  // Align, add/subtract, normalise, round and pack.
  always_comb begin
    w_ms_sh  = 27'd0;
    w_sticky = 1'b0;
    w_m      = 27'd0;
    w_e      = {2'b00, w_eb_n};
    w_rnd    = 1'b0;
    w_sig25  = 25'd0;
    w_sig    = 24'd0;
    result   = 32'd0;

    if (w_diff >= 8'd27) begin
      w_ms_sh  = 27'd0;
      w_sticky = |w_ms;
    end else begin
      w_ms_sh  = w_ms >> w_diff;
      w_sticky = |(w_ms & ((27'd1 << w_diff) - 27'd1));
    end
    w_ms_sh[0] = w_ms_sh[0] | w_sticky;

    if (w_sub) w_sum = {1'b0, w_mb} - {1'b0, w_ms_sh};
    else       w_sum = {1'b0, w_mb} + {1'b0, w_ms_sh};

    if (w_sum[27]) begin
      w_m = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = w_e + 10'd1;
    end else begin
      w_m = w_sum[26:0];
      for (int i = 0; i < 26; i++) begin
        if (!w_m[26] && (w_e > 10'd1)) begin
          w_m = w_m << 1;
          w_e = w_e - 10'd1;
        end
      end
    end

    w_rnd   = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_sig25 = {1'b0, w_m[26:3]} + {24'd0, w_rnd};
    if (w_sig25[24]) begin
      w_sig = w_sig25[24:1];
      w_e   = w_e + 10'd1;
    end else begin
      w_sig = w_sig25[23:0];
    end

    if (w_sum == 28'd0)
      result = {w_big[31] & w_sml[31], 31'd0};
    else if (w_e >= 10'd255)
      result = {w_big[31], 8'hFF, 23'd0};
    else if (!w_sig[23])
      result = {w_big[31], 8'h00, w_sig[22:0]};
    else
      result = {w_big[31], w_e[7:0], w_sig[22:0]};

    if (w_eb == 8'hFF) begin
      if ((w_big[22:0] != 23'd0) || ((w_es == 8'hFF) && w_sub))
        result = 32'h7FC0_0000;
      else
        result = w_big;
    end
  end

endmodule

// Arbiter and sequencer around one shared adder.
module ahfp_add_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_dataa,
  input  logic [31:0] req0_datab,
  input  logic [31:0] req1_dataa,
  input  logic [31:0] req1_datab,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_id;
  logic        r_last_grant;
  logic [31:0] r_rsp_result;
  logic        r_rsp_id;
  logic        r_rsp_valid;
  logic [15:0] r_op_count;

  logic        w_grant1;
  logic        w_accept;
  logic [31:0] w_sum;

  // The only adder; its inputs come straight from the operand registers,
  // which hold steady from LOAD through EXEC.
  ahfp_add u_add (
    .dataa  (r_opa),
    .datab  (r_opb),
    .result (w_sum)
  );

  // On a tie, round-robin picks whoever did not win last time.
  assign w_grant1 = (req0_valid && req1_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant)
                                               : req1_valid;
  assign req0_ready = !reset && (r_state == S_IDLE) && req0_valid && !w_grant1;
  assign req1_ready = !reset && (r_state == S_IDLE) && req1_valid &&  w_grant1;
  assign w_accept   = req0_ready || req1_ready;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != S_IDLE);
  assign op_count   = r_op_count;

  // Sequencer: accept, present operands, capture sum, hold until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_opa        <= 32'd0;
      r_opb        <= 32'd0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_result <= 32'd0;
      r_rsp_id     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opa        <= w_grant1 ? req1_dataa : req0_dataa;
            r_opb        <= w_grant1 ? req1_datab : req0_datab;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_rsp_result <= w_sum;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
